// File: rtl/poly_tone_sequencer.sv
// -----------------------------------------------------------------------------
// poly_tone_sequencer
//   Multi-channel square-wave tone sequencer. Timed notes arrive on a
//   valid/ready command port; each channel plays one active note and holds one
//   pending note so consecutive notes play gaplessly. Per-channel waves are
//   mixed (OR or XOR) into a registered speaker bit; the LED byte shows channel
//   activity plus the speaker bit on led[7].
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   ticks_per_milli  clk cycles per ms (0 behaves as 1)
//   pause            freezes prescaler, phase and duration counters
//   cmd_valid/ready  command handshake; out-of-range channels are dropped
//   cmd_ch           target channel
//   cmd_half_period  clk cycles per half wave, 0 = silent rest
//   cmd_dur_ms       note length in ms (0 behaves as 1)
//   ms_tick          one-cycle pulse per elapsed millisecond
//   busy             per-channel active-note flag
//   sound_ch         per-channel square wave
//   sound            registered mix of sound_ch
//   led              {sound, 0.., busy}, registered
// -----------------------------------------------------------------------------

// One tone channel: active note, 1-deep pending slot and the square wave.
module ptseq_lane #(
   parameter int HP_W  = 16,
   parameter int DUR_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pause,
   input  logic             tick,
   input  logic             acc,
   input  logic [HP_W-1:0]  cmd_hp,
   input  logic [DUR_W-1:0] cmd_dur,
   output logic             busy,
   output logic             wave,
   output logic             pend_full
);
   typedef enum logic {IDLE, PLAY} state_t;

   state_t           state;
   logic [HP_W-1:0]  hp, ph, pend_hp;
   logic [DUR_W-1:0] dur, pend_dur;
   logic [DUR_W-1:0] cmd_dur_n;
   logic             note_end;

   assign cmd_dur_n = (cmd_dur == '0) ? DUR_W'(1) : cmd_dur;
   // tick is already gated by pause, so a paused note never ends
   assign note_end  = (state == PLAY) && tick && (dur == DUR_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         wave      <= 1'b0;
         hp        <= '0;
         ph        <= '0;
         dur       <= '0;
         pend_full <= 1'b0;
         pend_hp   <= '0;
         pend_dur  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (acc) begin
                  state <= PLAY;
                  busy  <= 1'b1;
                  hp    <= cmd_hp;
                  dur   <= cmd_dur_n;
                  ph    <= '0;
                  wave  <= 1'b0;
               end
            end
            PLAY: begin
               if (note_end) begin
                  ph   <= '0;
                  wave <= 1'b0;
                  if (pend_full) begin
                     // gapless hand-over; acc cannot fire since ready was 0
                     hp        <= pend_hp;
                     dur       <= pend_dur;
                     pend_full <= 1'b0;
                  end else if (acc) begin
                     hp  <= cmd_hp;
                     dur <= cmd_dur_n;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  if (tick) dur <= dur - DUR_W'(1);
                  if (acc) begin
                     pend_full <= 1'b1;
                     pend_hp   <= cmd_hp;
                     pend_dur  <= cmd_dur_n;
                  end
                  if (hp != '0 && !pause) begin
                     if (ph == hp - HP_W'(1)) begin
                        ph   <= '0;
                        wave <= ~wave;
                     end else begin
                        ph <= ph + HP_W'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

module poly_tone_sequencer #(
   parameter int NUM_CH   = 4,
   parameter int HP_W     = 16,
   parameter int DUR_W    = 12,
   parameter int MIX_MODE = 0,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       ticks_per_milli,
   input  logic              pause,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [HP_W-1:0]   cmd_half_period,
   input  logic [DUR_W-1:0]  cmd_dur_ms,
   output logic              ms_tick,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] sound_ch,
   output logic              sound,
   output logic [7:0]        led
);
   logic [15:0]       pre_cnt, t_last;
   logic [NUM_CH-1:0] pend_full, acc;
   logic              mix_n;
   logic [7:0]        led_n;

   // ---- millisecond prescaler ----
   assign t_last  = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
   // >= rather than == so a shrinking period still wraps immediately
   assign ms_tick = !pause && (pre_cnt >= t_last);

   always_ff @(posedge clk) begin
      if (!rst_n)      pre_cnt <= '0;
      else if (!pause) pre_cnt <= ms_tick ? 16'd0 : pre_cnt + 16'd1;
   end

   // ---- command port: out-of-range channels are always ready (dropped) ----
   always_comb begin
      cmd_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         if (cmd_ch == CH_W'(i)) cmd_ready = ~pend_full[i];
   end

   // ---- channels ----
   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      assign acc[i] = cmd_valid && cmd_ready && (cmd_ch == CH_W'(i));

      ptseq_lane #(.HP_W(HP_W), .DUR_W(DUR_W)) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .pause     (pause),
         .tick      (ms_tick),
         .acc       (acc[i]),
         .cmd_hp    (cmd_half_period),
         .cmd_dur   (cmd_dur_ms),
         .busy      (busy[i]),
         .wave      (sound_ch[i]),
         .pend_full (pend_full[i])
      );
   end

   // ---- mixer and LEDs, one register stage ----
   always_comb begin
      mix_n = (MIX_MODE != 0) ? ^sound_ch : |sound_ch;
      led_n = '0;
      led_n[NUM_CH-1:0] = busy;
      led_n[7] = mix_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sound <= 1'b0;
         led   <= '0;
      end else begin
         sound <= mix_n;
         led   <= led_n;
      end
   end
endmodule

// File: tb/tb_poly_tone_sequencer.sv
// Scoreboard bench: stimulus schedules expected values against absolute cycle
// numbers; a negedge monitor pops and compares entries as their cycle arrives.
module tb_poly_tone_sequencer;
   localparam int NUM_CH = 5;
   localparam int HP_W   = 16;
   localparam int DUR_W  = 12;
   localparam int CH_W   = 3;

   localparam int S_BUSY = 0, S_SCH = 1, S_SND = 2, S_LED = 3, S_RDY = 4, S_TICK = 5;

   logic              clk, rst_n, pause, cmd_valid, cmd_ready, ms_tick, sound;
   logic [15:0]       tpm;
   logic [CH_W-1:0]   cmd_ch;
   logic [HP_W-1:0]   cmd_hp;
   logic [DUR_W-1:0]  cmd_dur;
   logic [NUM_CH-1:0] busy, sound_ch;
   logic [7:0]        led;

   poly_tone_sequencer #(.NUM_CH(NUM_CH), .HP_W(HP_W), .DUR_W(DUR_W), .MIX_MODE(1)) dut (
      .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .pause(pause),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
      .cmd_half_period(cmd_hp), .cmd_dur_ms(cmd_dur), .ms_tick(ms_tick),
      .busy(busy), .sound_ch(sound_ch), .sound(sound), .led(led));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {int cyc; int sig; int val; string name;} chk_t;
   chk_t sb[$];
   int   cyc = 0;
   int   n_chk = 0, n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sample(int sig);
      case (sig)
         S_BUSY: return int'(busy);
         S_SCH:  return int'(sound_ch);
         S_SND:  return int'(sound);
         S_LED:  return int'(led);
         S_RDY:  return int'(cmd_ready);
         default: return int'(ms_tick);
      endcase
   endfunction

   always @(negedge clk) begin
      chk_t keep[$];
      int   act;
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].cyc <= cyc) begin
            n_chk++;
            act = sample(sb[i].sig);
            if (sb[i].cyc < cyc || act != sb[i].val) begin
               n_fail++;
               $display("FAIL %s cyc %0d: got 0x%0h expected 0x%0h", sb[i].name, sb[i].cyc, act, sb[i].val);
            end
         end else keep.push_back(sb[i]);
      end
      sb = keep;
   end

   task automatic exp_at(input int c, input int s, input int v, input string n);
      sb.push_back('{c, s, v, n});
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic send(input int ch, input int hp, input int dur);
      cmd_valid = 1'b1;
      cmd_ch    = CH_W'(ch);
      cmd_hp    = HP_W'(hp);
      cmd_dur   = DUR_W'(dur);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: test did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 0; pause = 0; tpm = 16'd10; cmd_valid = 0; cmd_ch = '0; cmd_hp = '0; cmd_dur = '0;

      // reset; prescaler starts at 0 after edge 3, ticks in cycles 12, 22, ...
      goto(3); rst_n = 1;
      exp_at(3, S_BUSY, 0, "rst_busy");  exp_at(3, S_SCH, 0, "rst_sch");
      exp_at(3, S_SND, 0, "rst_snd");    exp_at(3, S_LED, 0, "rst_led");
      exp_at(3, S_RDY, 1, "rst_rdy");    exp_at(3, S_TICK, 0, "rst_tick");
      exp_at(12, S_TICK, 1, "tick12");   exp_at(13, S_TICK, 0, "tick13");

      // single note: ch0 hp=5 dur=3, loaded at edge 21, ends at tick edge 43
      goto(20); send(0, 5, 3);
      exp_at(20, S_RDY, 1, "t1_rdy");    exp_at(21, S_BUSY, 1, "t1_busy_on");
      exp_at(21, S_SCH, 0, "t1_sch21");  exp_at(25, S_SCH, 0, "t1_sch25");
      exp_at(26, S_SCH, 1, "t1_sch26");  exp_at(31, S_SCH, 0, "t1_sch31");
      exp_at(36, S_SCH, 1, "t1_sch36");  exp_at(26, S_SND, 0, "t1_snd26");
      exp_at(27, S_SND, 1, "t1_snd27");  exp_at(22, S_LED, 8'h01, "t1_led22");
      exp_at(27, S_LED, 8'h81, "t1_led27"); exp_at(42, S_BUSY, 1, "t1_busy42");
      exp_at(43, S_BUSY, 0, "t1_busy_off"); exp_at(43, S_SCH, 0, "t1_sch43");
      exp_at(44, S_LED, 0, "t1_led44");
      goto(21); cmd_valid = 0;

      // pending slot: three ch0 notes back to back
      goto(50); send(0, 2, 1);
      exp_at(51, S_BUSY, 1, "t2_busy51"); exp_at(52, S_SCH, 0, "t2_sch52");
      exp_at(52, S_RDY, 0, "t2_rdy_full"); exp_at(53, S_RDY, 1, "t2_rdy53");
      exp_at(53, S_BUSY, 1, "t2_gapless"); exp_at(53, S_SCH, 0, "t2_sch53");
      exp_at(55, S_SCH, 0, "t2_sch55");  exp_at(56, S_SCH, 1, "t2_sch56");
      exp_at(60, S_RDY, 0, "t2_rdy60");  exp_at(73, S_BUSY, 1, "t2_busy73");
      exp_at(74, S_RDY, 1, "t2_rdy74");  exp_at(76, S_SCH, 0, "t2_sch76");
      exp_at(77, S_SCH, 1, "t2_sch77");  exp_at(82, S_BUSY, 1, "t2_busy82");
      exp_at(83, S_BUSY, 0, "t2_busy83");
      goto(51); send(0, 3, 2);
      goto(52); send(0, 4, 1);
      goto(54); cmd_valid = 0;

      // two channels, XOR mix
      goto(90); send(0, 3, 5);
      exp_at(92, S_BUSY, 3, "t3_busy");  exp_at(94, S_SCH, 1, "t3_sch94");
      exp_at(95, S_SND, 1, "t3_snd95");  exp_at(96, S_SCH, 3, "t3_sch96");
      exp_at(97, S_SND, 0, "t3_snd97");  exp_at(97, S_SCH, 2, "t3_sch97");
      exp_at(97, S_LED, 8'h03, "t3_led97"); exp_at(98, S_SND, 1, "t3_snd98");
      exp_at(98, S_LED, 8'h83, "t3_led98"); exp_at(100, S_SCH, 1, "t3_sch100");
      exp_at(132, S_BUSY, 3, "t3_busy132"); exp_at(133, S_BUSY, 0, "t3_busy133");
      goto(91); send(1, 4, 5);
      goto(92); cmd_valid = 0;

      // out-of-range channels dropped; rest note on ch2
      goto(140); send(5, 7, 1);
      exp_at(140, S_RDY, 1, "t4_rdy_ch5"); exp_at(141, S_RDY, 1, "t4_rdy_ch7");
      exp_at(141, S_BUSY, 0, "t4_busy141"); exp_at(142, S_BUSY, 0, "t4_busy142");
      exp_at(143, S_BUSY, 4, "t4_rest_on"); exp_at(150, S_SCH, 0, "t4_rest_sch");
      exp_at(150, S_BUSY, 4, "t4_busy150"); exp_at(162, S_BUSY, 4, "t4_busy162");
      exp_at(163, S_BUSY, 0, "t4_rest_off");
      goto(141); send(7, 7, 1);
      goto(142); send(2, 0, 2);
      goto(143); cmd_valid = 0;

      // pause for 50 cycles mid-note on ch3
      goto(170); send(3, 5, 2);
      exp_at(171, S_BUSY, 8, "t5_busy171"); exp_at(175, S_SCH, 0, "t5_sch175");
      exp_at(182, S_TICK, 0, "t5_tick182"); exp_at(200, S_TICK, 0, "t5_tick200");
      exp_at(200, S_BUSY, 8, "t5_busy200"); exp_at(200, S_SCH, 0, "t5_sch200");
      exp_at(226, S_SCH, 8, "t5_sch226");  exp_at(231, S_SCH, 0, "t5_sch231");
      exp_at(232, S_TICK, 1, "t5_tick232"); exp_at(232, S_BUSY, 8, "t5_busy232");
      exp_at(233, S_BUSY, 0, "t5_busy233");
      goto(171); cmd_valid = 0;
      goto(175); pause = 1;
      goto(225); pause = 0;

      // ticks_per_milli = 0: tick every cycle
      goto(240); tpm = 16'd0;
      exp_at(241, S_TICK, 1, "t6_tick241"); exp_at(242, S_TICK, 1, "t6_tick242");
      exp_at(244, S_BUSY, 1, "t6_busy244"); exp_at(245, S_SCH, 1, "t6_sch245");
      exp_at(246, S_SCH, 0, "t6_sch246");  exp_at(246, S_BUSY, 1, "t6_busy246");
      exp_at(247, S_BUSY, 0, "t6_busy247");
      goto(243); send(0, 1, 3);
      goto(244); cmd_valid = 0;

      // reset mid-note
      goto(250); tpm = 16'd10; send(1, 2, 5);
      exp_at(251, S_BUSY, 2, "t7_busy251"); exp_at(253, S_SCH, 2, "t7_sch253");
      exp_at(256, S_BUSY, 2, "t7_busy256");
      exp_at(257, S_BUSY, 0, "t7_busy_rst"); exp_at(257, S_SCH, 0, "t7_sch_rst");
      exp_at(257, S_SND, 0, "t7_snd_rst");   exp_at(257, S_LED, 0, "t7_led_rst");
      exp_at(257, S_RDY, 1, "t7_rdy_rst");   exp_at(257, S_TICK, 0, "t7_tick_rst");
      exp_at(258, S_BUSY, 0, "t7_busy258");  exp_at(258, S_TICK, 0, "t7_tick258");
      goto(251); cmd_valid = 0;
      goto(256); rst_n = 0;
      goto(257); rst_n = 1;

      goto(260);
      while (sb.size() != 0 && cyc < 300) begin @(posedge clk); #1; end
      foreach (sb[i]) begin
         n_chk++; n_fail++;
         $display("FAIL %s cyc %0d: never checked, expected 0x%0h", sb[i].name, sb[i].cyc, sb[i].val);
      end

      n_chk++;
      if (busy !== '0) begin n_fail++; $display("FAIL end_busy: got 0x%0h expected 0", busy); end
      n_chk++;
      if (sound_ch !== '0) begin n_fail++; $display("FAIL end_sch: got 0x%0h expected 0", sound_ch); end
      n_chk++;
      if (sound !== 1'b0) begin n_fail++; $display("FAIL end_snd: got %b expected 0", sound); end
      n_chk++;
      if (led !== 8'h00) begin n_fail++; $display("FAIL end_led: got 0x%0h expected 0", led); end
      n_chk++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL end_rdy: got %b expected 1", cmd_ready); end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
